multicycle_control_unit: RTL

//   Multicycle RV32I control FSM. Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK.

---
 rtl/cu_pkg.sv | 89 ++++++++
 rtl/control_decoder.sv | 89 ++++++++
 rtl/multicycle_control_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared encodings, state enum and control bundle for the multicycle control unit.
package cu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd13;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  // Everything the FSM needs to remember about the instruction after DECODE.
  typedef struct packed {
    logic [3:0] alu_op;
    logic [2:0] imm_sel;
    logic       a_sel;
    logic       b_sel;
    logic       br_un;
    logic [1:0] wb_sel;
    logic       is_branch;
    logic       is_load;
    logic       is_store;
    logic       is_jump;
    logic [2:0] funct3;
  } ctrl_t;

  // Shared func3 -> ALU op map for the register and immediate ALU groups.
  function automatic logic [3:0] alu_base(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'd0:    op = ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Branch resolution; BrLT already carries the signed/unsigned choice via BrUn.
  function automatic logic branch_taken(input logic [2:0] f3, input logic br_eq,
                                        input logic br_lt);
    logic t;
    case (f3)
      3'b000:         t = br_eq;
      3'b001:         t = !br_eq;
      3'b100, 3'b110: t = br_lt;
      3'b101, 3'b111: t = !br_lt;
      default:        t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational RV32I decoder: instruction word -> control bundle plus illegal flag.
module control_decoder
  import cu_pkg::*;
#(
  parameter int unsigned HAS_MEM = 1
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_instr_bits;

  assign opcode            = instr_i[6:0];
  assign f3                = instr_i[14:12];
  assign f7                = instr_i[31:25];
  assign unused_instr_bits = ^{instr_i[24:15], instr_i[11:7]};

  // Decode opcode/func3/func7 into datapath selects; anything unlisted is illegal.
  always_comb begin
    ctrl_o        = '0;
    ctrl_o.funct3 = f3;
    illegal_o     = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (f7 == 7'h00)                     ctrl_o.alu_op = alu_base(f3);
        else if (f7 == 7'h20 && f3 == 3'd0) ctrl_o.alu_op = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) ctrl_o.alu_op = ALU_SRA;
        else                                 illegal_o = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl_o.b_sel = 1'b1;
        ctrl_o.alu_op = alu_base(f3);
        if (f3 == 3'd1 && f7 != 7'h00) illegal_o = 1'b1;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20)      ctrl_o.alu_op = ALU_SRA;
          else if (f7 != 7'h00) illegal_o = 1'b1;
        end
      end
      OPC_LOAD: begin
        ctrl_o.is_load = 1'b1;
        ctrl_o.b_sel   = 1'b1;
        ctrl_o.wb_sel  = WB_MEM;
        if (HAS_MEM == 0 || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) illegal_o = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.is_store = 1'b1;
        ctrl_o.b_sel    = 1'b1;
        ctrl_o.imm_sel  = IMM_S;
        if (HAS_MEM == 0 || f3 > 3'd2) illegal_o = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.is_branch = 1'b1;
        ctrl_o.a_sel     = 1'b1;
        ctrl_o.b_sel     = 1'b1;
        ctrl_o.imm_sel   = IMM_B;
        ctrl_o.br_un     = f3[1];
        if (f3 == 3'd2 || f3 == 3'd3) illegal_o = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o.is_jump = 1'b1;
        ctrl_o.a_sel   = 1'b1;
        ctrl_o.b_sel   = 1'b1;
        ctrl_o.imm_sel = IMM_J;
        ctrl_o.wb_sel  = WB_PC4;
      end
      OPC_JALR: begin
        ctrl_o.is_jump = 1'b1;
        ctrl_o.b_sel   = 1'b1;
        ctrl_o.wb_sel  = WB_PC4;
        if (f3 != 3'd0) illegal_o = 1'b1;
      end
      OPC_LUI: begin
        ctrl_o.b_sel   = 1'b1;
        ctrl_o.imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl_o.a_sel   = 1'b1;
        ctrl_o.b_sel   = 1'b1;
        ctrl_o.imm_sel = IMM_U;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequencing, registered selects, branch resolution,
// data-memory handshake with timeout.
//
//   state  | meaning
//   FETCH  | idle, waiting for instr_valid; pulses ir_load on capture
//   DECODE | decode IR, register selects, trap on illegal encodings
//   EXEC   | ALU step; branches resolve and retire here
//   MEM    | hold mem_req until mem_ready or timeout
//   WB     | regfile write and PC update
//   TRAP   | sticky fault, left only by reset
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned HAS_MEM     = 1
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               instr_valid_i,
  input  logic [31:0]        Instruction_i,
  input  logic               BrEq_i,
  input  logic               BrLT_i,
  input  logic               mem_ready_i,
  output logic [ALUOP_W-1:0] ALUop_o,
  output logic [2:0]         ImmSel_o,
  output logic               ASel_o,
  output logic               BSel_o,
  output logic               BrUn_o,
  output logic [1:0]         WBSel_o,
  output logic               wEn_o,
  output logic               MemRW_o,
  output logic               mem_req_o,
  output logic               ir_load_o,
  output logic               pc_wen_o,
  output logic               PCSel_o,
  output logic               busy_o,
  output logic               trap_o
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ctrl_t             dec_ctrl;
  logic              dec_illegal;
  logic              ir_load, pc_wen, pc_sel, wen, mem_req;

  control_decoder #(.HAS_MEM(HAS_MEM)) u_decoder (
    .instr_i   (Instruction_i),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  // State, decoded selects and MEM timeout counter; reset aborts anything in flight.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= FETCH;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and strobe logic; the counter only survives while staying in MEM.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    cnt_d   = '0;
    ir_load = 1'b0;
    pc_wen  = 1'b0;
    pc_sel  = 1'b0;
    wen     = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      FETCH: begin
        if (instr_valid_i) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (dec_illegal) begin
          state_d = TRAP;
        end else begin
          ctrl_d  = dec_ctrl;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (ctrl_q.is_branch) begin
          pc_wen  = 1'b1;
          pc_sel  = branch_taken(ctrl_q.funct3, BrEq_i, BrLT_i);
          state_d = FETCH;
        end else if (ctrl_q.is_load || ctrl_q.is_store) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        if (mem_ready_i) begin
          if (ctrl_q.is_store) begin
            pc_wen  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB: begin
        wen     = 1'b1;
        pc_wen  = 1'b1;
        pc_sel  = ctrl_q.is_jump;
        state_d = FETCH;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  assign ALUop_o   = ALUOP_W'(ctrl_q.alu_op);
  assign ImmSel_o  = ctrl_q.imm_sel;
  assign ASel_o    = ctrl_q.a_sel;
  assign BSel_o    = ctrl_q.b_sel;
  assign BrUn_o    = ctrl_q.br_un;
  assign WBSel_o   = ctrl_q.wb_sel;
  assign wEn_o     = wen;
  assign MemRW_o   = mem_req & ctrl_q.is_store;
  assign mem_req_o = mem_req;
  assign ir_load_o = ir_load;
  assign pc_wen_o  = pc_wen;
  assign PCSel_o   = pc_sel;
  assign busy_o    = (state_q != FETCH);
  assign trap_o    = (state_q == TRAP);

endmodule
